// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns one EXE-stage load/store into a request/grant/rvalid bus transaction.
// Optional build macro MISALIGN_CHK_EN: trap misaligned half/word accesses instead of issuing them.
module dmem_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            adr_v_i,
    input  logic [XLEN-1:0] adr_i,
    input  logic            is_store_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [2:0]      access_size_i,
    output logic [XLEN-1:0] load_data_o,
    output logic            stall_o,
    output logic            misalign_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_adr_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP,
        DONE
    } state_t;

    state_t          state;
    logic [1:0]      off_q;
    logic            req_q;
    logic            we_q;
    logic [3:0]      be_q;
    logic [XLEN-1:0] adr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] load_data_q;

    logic [1:0]      off;
    logic [3:0]      be_nxt;
    logic [XLEN-1:0] wdata_nxt;

    assign off       = adr_i[1:0];
    assign wdata_nxt = store_data_i << {off, 3'b000};

    // Half enables shifted past lane 3 are dropped by the 4-bit result width.
    always_comb begin
        be_nxt = 4'b1111;
        case (access_size_i)
            3'b001:  be_nxt = 4'b0001 << off;
            3'b010:  be_nxt = 4'b0011 << off;
            default: be_nxt = 4'b1111;
        endcase
    end

`ifdef MISALIGN_CHK_EN
    logic misaligned;
    assign misaligned = (access_size_i == 3'b010 && off[0]) ||
                        (access_size_i == 3'b100 && off != 2'b00);
    assign misalign_o = (state == IDLE) && adr_v_i && misaligned;
`else
    assign misalign_o = 1'b0;
`endif

    // Stall must rise in the acceptance cycle itself, so it cannot be registered.
    assign stall_o = (state == REQ) || (state == RSP) || (state == IDLE && adr_v_i);

    // NOTE: every register here is state, so all assignments are non-blocking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            off_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            be_q        <= '0;
            adr_q       <= '0;
            wdata_q     <= '0;
            load_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (adr_v_i) begin
                        adr_q   <= {adr_i[XLEN-1:2], 2'b00};
                        wdata_q <= wdata_nxt;
                        off_q   <= off;
`ifdef MISALIGN_CHK_EN
                        if (misaligned) begin
                            load_data_q <= '0;
                            state       <= DONE;
                        end else begin
                            req_q <= 1'b1;
                            we_q  <= is_store_i;
                            be_q  <= be_nxt;
                            state <= REQ;
                        end
`else
                        req_q <= 1'b1;
                        we_q  <= is_store_i;
                        be_q  <= be_nxt;
                        state <= REQ;
`endif
                    end
                end
                REQ: begin
                    if (dmem_gnt_i) begin
                        req_q <= 1'b0;
                        we_q  <= 1'b0;
                        be_q  <= '0;
                        state <= we_q ? DONE : RSP;
                    end
                end
                RSP: begin
                    if (dmem_rvalid_i) begin
                        load_data_q <= dmem_rdata_i >> {off_q, 3'b000};
                        state       <= DONE;
                    end
                end
                // adr_v_i seen here still belongs to the completing instruction.
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_be_o    = be_q;
    assign dmem_adr_o   = adr_q;
    assign dmem_wdata_o = wdata_q;
    assign load_data_o  = load_data_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: a transaction-timeline model predicts every output each cycle.
// Compile with MISALIGN_CHK_EN defined to exercise the misalignment trap as well.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        adr_v_i;
    logic [31:0] adr_i;
    logic        is_store_i;
    logic [31:0] store_data_i;
    logic [2:0]  access_size_i;
    logic [31:0] load_data_o;
    logic        stall_o;
    logic        misalign_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_adr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;

    always #5 clk = ~clk;

    dmem_ctrl #(.XLEN(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .adr_v_i       (adr_v_i),
        .adr_i         (adr_i),
        .is_store_i    (is_store_i),
        .store_data_i  (store_data_i),
        .access_size_i (access_size_i),
        .load_data_o   (load_data_o),
        .stall_o       (stall_o),
        .misalign_o    (misalign_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_adr_o    (dmem_adr_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i)
    );

    int checks   = 0;
    int failures = 0;

    // Expected outputs for the current cycle, written by the stimulus before each sampling edge.
    bit          chk_on = 1'b0;
    logic        e_stall, e_req, e_we, e_mis;
    logic [3:0]  e_be;
    logic [31:0] e_adr, e_wdata, e_ld;
    bit          e_fields;

    int          grants    = 0;
    int          req_cyc   = 0;
    int          stall_cnt = 0;
    int          mis_cnt   = 0;
    logic [31:0] last_adr, last_wdata;
    logic [3:0]  last_be;
    logic        last_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] model_be(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] b;
        case (size)
            3'b001:  b = 4'b0001 << off;
            3'b010:  b = 4'b0011 << off;
            default: b = 4'b1111;
        endcase
        return b;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            check("stall_o",     {31'd0, stall_o},    {31'd0, e_stall});
            check("dmem_req_o",  {31'd0, dmem_req_o}, {31'd0, e_req});
            check("dmem_we_o",   {31'd0, dmem_we_o},  {31'd0, e_we});
            check("dmem_be_o",   {28'd0, dmem_be_o},  {28'd0, e_be});
            check("misalign_o",  {31'd0, misalign_o}, {31'd0, e_mis});
            check("load_data_o", load_data_o, e_ld);
            if (e_fields) begin
                check("dmem_adr_o",   dmem_adr_o,   e_adr);
                check("dmem_wdata_o", dmem_wdata_o, e_wdata);
            end
            if (dmem_req_o) begin
                req_cyc++;
                last_adr   = dmem_adr_o;
                last_wdata = dmem_wdata_o;
                last_be    = dmem_be_o;
                last_we    = dmem_we_o;
                if (dmem_gnt_i) grants++;
            end
            if (stall_o)    stall_cnt++;
            if (misalign_o) mis_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_quiet(input logic stall);
        e_stall  = stall;
        e_req    = 1'b0;
        e_we     = 1'b0;
        e_be     = 4'b0000;
        e_mis    = 1'b0;
        e_fields = 1'b0;
    endtask

    // Drives one access from its IDLE acceptance cycle through DONE; caller is in an IDLE cycle.
    task automatic do_access(input logic [31:0] adr, input bit st, input logic [31:0] data,
                             input logic [2:0] size, input int gw, input int rw,
                             input logic [31:0] rdata, input bit b2b);
        logic [1:0]  off;
        logic [3:0]  be;
        logic [31:0] wd;
        bit          mis;
        off = adr[1:0];
        be  = model_be(size, off);
        wd  = data << (8 * off);
        mis = 1'b0;
`ifdef MISALIGN_CHK_EN
        mis = (size == 3'b010 && adr[0]) || (size == 3'b100 && off != 2'b00);
`endif
        adr_v_i       = 1'b1;
        adr_i         = adr;
        is_store_i    = st;
        store_data_i  = data;
        access_size_i = size;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'($urandom % 2);
        dmem_rdata_i  = $urandom;
        exp_quiet(1'b1);
        e_mis = mis;
        tick();
        if (mis) begin
            e_ld = 32'd0;
        end else begin
            for (int g = 0; g <= gw; g++) begin
                dmem_gnt_i    = (g == gw);
                dmem_rvalid_i = 1'($urandom % 2);
                dmem_rdata_i  = $urandom;
                exp_quiet(1'b1);
                e_req    = 1'b1;
                e_we     = st;
                e_be     = be;
                e_adr    = {adr[31:2], 2'b00};
                e_wdata  = wd;
                e_fields = 1'b1;
                tick();
            end
            if (!st) begin
                for (int r = 0; r <= rw; r++) begin
                    dmem_gnt_i    = 1'($urandom % 2);
                    dmem_rvalid_i = (r == rw);
                    dmem_rdata_i  = (r == rw) ? rdata : $urandom;
                    exp_quiet(1'b1);
                    tick();
                end
                e_ld = rdata >> (8 * off);
            end
        end
        adr_v_i       = b2b ? 1'b1 : 1'($urandom % 2);
        dmem_gnt_i    = 1'($urandom % 2);
        dmem_rvalid_i = 1'($urandom % 2);
        dmem_rdata_i  = $urandom;
        exp_quiet(1'b0);
        tick();
        if (!b2b) begin
            adr_v_i       = 1'b0;
            dmem_gnt_i    = 1'($urandom % 2);
            dmem_rvalid_i = 1'($urandom % 2);
            exp_quiet(1'b0);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, r0, s0;
        reset         = 1'b1;
        adr_v_i       = 1'b0;
        adr_i         = '0;
        is_store_i    = 1'b0;
        store_data_i  = '0;
        access_size_i = 3'b100;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = '0;
        tick();
        tick();
        reset = 1'b0;
        exp_quiet(1'b0);
        e_fields = 1'b1;
        e_adr    = 32'd0;
        e_wdata  = 32'd0;
        e_ld     = 32'd0;
        chk_on   = 1'b1;
        tick();

        // Word load 0x100, immediate gnt, rvalid one cycle later.
        s0 = stall_cnt;
        do_access(32'h100, 1'b0, 32'd0, 3'b100, 0, 0, 32'hDEADBEEF, 1'b0);
        #1;
        check("r035_adr",   last_adr, 32'h100);
        check("r035_be",    {28'd0, last_be}, 32'hF);
        check("r035_ld",    load_data_o, 32'hDEADBEEF);
        check("r035_stall", stall_cnt - s0, 3);

        // Byte store 0xAB to 0x203.
        do_access(32'h203, 1'b1, 32'h000000AB, 3'b001, 0, 0, 32'd0, 1'b0);
        #1;
        check("r036_adr",   last_adr, 32'h200);
        check("r036_be",    {28'd0, last_be}, 32'h8);
        check("r036_wdata", {24'd0, last_wdata[31:24]}, 32'hAB);
        check("r036_we",    {31'd0, last_we}, 32'd1);

        // Load with gnt held off for five cycles.
        g0 = grants; r0 = req_cyc; s0 = stall_cnt;
        do_access(32'h1002, 1'b0, 32'd0, 3'b001, 5, 1, 32'h11223344, 1'b0);
        #1;
        check("r037_req_cycles", req_cyc - r0, 6);
        check("r037_grants",     grants - g0, 1);
        check("r037_stall",      stall_cnt - s0, 9);
        check("r037_ld",         load_data_o, 32'h00001122);

        // Two back-to-back loads, adr_v_i held high through the first DONE.
        g0 = grants; r0 = req_cyc;
        do_access(32'h40, 1'b0, 32'd0, 3'b100, 0, 0, 32'hCAFEF00D, 1'b1);
        do_access(32'h44, 1'b0, 32'd0, 3'b100, 0, 0, 32'h0BADC0DE, 1'b0);
        #1;
        check("r038_grants",     grants - g0, 2);
        check("r038_req_cycles", req_cyc - r0, 2);

        // Reset during RSP, then a late rvalid must be discarded.
        adr_v_i = 1'b1; adr_i = 32'h300; is_store_i = 1'b0; access_size_i = 3'b100;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        exp_quiet(1'b1);
        tick();
        dmem_gnt_i = 1'b1;
        exp_quiet(1'b1);
        e_req = 1'b1; e_be = 4'hF; e_fields = 1'b1; e_adr = 32'h300; e_wdata = 32'd0;
        tick();
        dmem_gnt_i = 1'b0; reset = 1'b1;
        exp_quiet(1'b1);
        tick();
        reset = 1'b0; adr_v_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h12345678;
        exp_quiet(1'b0);
        e_fields = 1'b1; e_adr = 32'd0; e_wdata = 32'd0; e_ld = 32'd0;
        tick();
        dmem_rvalid_i = 1'b0;
        tick();
        #1;
        check("r039_ld",    load_data_o, 32'd0);
        check("r039_stall", {31'd0, stall_o}, 32'd0);
        e_fields = 1'b0;

`ifdef MISALIGN_CHK_EN
        r0 = req_cyc; s0 = mis_cnt;
        do_access(32'h102, 1'b0, 32'd0, 3'b100, 0, 0, 32'hFFFFFFFF, 1'b0);
        #1;
        check("r040_req_cycles", req_cyc - r0, 0);
        check("r040_pulses",     mis_cnt - s0, 1);
        check("r040_ld",         load_data_o, 32'd0);
`else
        // Misaligned half at lane 3 is issued with its upper enable truncated away.
        do_access(32'h507, 1'b1, 32'h0000BEEF, 3'b010, 1, 0, 32'd0, 1'b0);
        #1;
        check("trunc_be",    {28'd0, last_be}, 32'h8);
        check("trunc_wdata", last_wdata, 32'hEF000000);
        check("no_misalign", mis_cnt, 0);
`endif

        for (int i = 0; i < 60; i++) begin
            logic [2:0] sz;
            case ($urandom % 3)
                0:       sz = 3'b001;
                1:       sz = 3'b010;
                default: sz = 3'b100;
            endcase
            do_access($urandom, 1'($urandom % 2), $urandom, sz,
                      int'($urandom % 4), int'($urandom % 4), $urandom, 1'($urandom % 2));
        end
        adr_v_i = 1'b0;
        exp_quiet(1'b0);
        tick();
        chk_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter XLEN, default 32, is the data/address width; only 32 is supported.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 adr_v_i  in  1  the EXE stage presents a memory access this cycle.
REQ-005 adr_i  in  XLEN  byte address of the access.
REQ-006 is_store_i  in  1  1 = store, 0 = load.
REQ-007 store_data_i  in  XLEN  store data, LSB-aligned.
REQ-008 access_size_i  in  3  size, one-hot: 001 = byte, 010 = half, 100 = word.
REQ-009 load_data_o  out  XLEN  load word shifted right by adr_i[1:0]*8, with no extension.
REQ-010 stall_o  out  1  EXE must hold its presented access stable while this is 1.
REQ-011 misalign_o  out  1  one-cycle pulse reporting a misaligned access.
REQ-012 dmem_req_o  out  1  bus request.
REQ-013 dmem_we_o  out  1  bus write enable.
REQ-014 dmem_adr_o  out  XLEN  word address; bits [1:0] are forced to 0.
REQ-015 dmem_be_o  out  4  byte enables.
REQ-016 dmem_wdata_o  out  XLEN  write data placed on the addressed byte lanes.
REQ-017 dmem_gnt_i  in  1  bus has accepted the request.
REQ-018 dmem_rvalid_i  in  1  read data is valid.
REQ-019 dmem_rdata_i  in  XLEN  read data.

Function
REQ-020 The FSM SHALL have four states: IDLE, REQ, RSP and DONE.
REQ-021 IDLE: when adr_v_i=1, the block SHALL capture adr, we, size and aligned wdata into registers, assert stall_o combinationally in the same cycle, and go to REQ next cycle.
REQ-022 REQ: the block SHALL hold dmem_req_o=1 and all bus fields stable until dmem_gnt_i=1; on gnt, a store SHALL go to DONE and a load SHALL go to RSP.
REQ-023 RSP: dmem_req_o=0; on dmem_rvalid_i=1 the block SHALL register the shifted rdata into the load data register and go to DONE.
REQ-024 DONE: stall_o=0 and load_data_o shows the registered value; adr_v_i SHALL be ignored because it belongs to the completing instruction; next state is IDLE.
REQ-025 stall_o SHALL be 1 in REQ and RSP, 1 in IDLE when adr_v_i=1, and 0 otherwise.
REQ-026 Byte enables SHALL be: byte 0001<<adr[1:0]; half 0011<<adr[1:0], truncated to 4 bits; word 1111.
REQ-027 dmem_wdata_o SHALL be store_data shifted left by adr[1:0]*8, truncated to XLEN.
REQ-028 dmem_rvalid_i outside RSP and dmem_gnt_i outside REQ SHALL be ignored.
REQ-029 Minimum latency SHALL be: a store with gnt on its first REQ cycle completes in DONE at cycle +2; a load with gnt and rvalid each on first opportunity completes at +3.
REQ-030 Outside REQ, dmem_req_o, dmem_we_o and dmem_be_o SHALL be 0.

Reset
REQ-031 While reset=1 the FSM SHALL go to IDLE and all registers clear to 0, so every output reads 0 on the cycle after reset.
REQ-032 A reset in REQ or RSP SHALL abandon the access, drop dmem_req_o on the following cycle, and discard any late rvalid.

Configuration
REQ-033 With MISALIGN_CHK_EN defined, a half access with adr[0]=1 or a word access with adr[1:0]!=0 SHALL issue no bus request, pulse misalign_o in the IDLE acceptance cycle, go directly to DONE, and return load_data_o=0.
REQ-034 Without MISALIGN_CHK_EN, misalign_o SHALL be tied 0 and misaligned accesses SHALL be issued with the truncated byte enables of REQ-026.

Verification
REQ-035 Word load to 0x100, gnt immediate, rvalid 1 cycle later with rdata 0xDEADBEEF -> dmem_adr_o=0x100, be=1111, load_data_o=0xDEADBEEF in DONE, stall_o high for 3 cycles.
REQ-036 Byte store 0xAB to 0x203 -> dmem_adr_o=0x200, be=1000, wdata[31:24]=0xAB, we=1.
REQ-037 Load with gnt held low for 5 cycles -> req and fields stable for 6 cycles, stall_o held throughout, single completion.
REQ-038 Back-to-back loads with adr_v_i held high through DONE -> exactly two bus requests, none issued during DONE.
REQ-039 Reset asserted in RSP, then rvalid arrives -> FSM in IDLE, load_data_o=0, stall_o=0.
REQ-040 With MISALIGN_CHK_EN, word load to 0x102 -> no dmem_req_o, one misalign_o pulse, DONE on the next cycle.
